// File: rtl/bus_arbiter_2to1.sv
// bus_arbiter_2to1: round-robin arbiter sharing one Manta register bus between two host
// bridges (A = Ethernet, B = UART), with one request slot per bridge and a response timeout.
module bus_arbiter_2to1 #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_wdata_i,
  input  logic                  a_rw_i,
  input  logic                  a_valid_i,
  output logic                  a_busy_o,
  output logic                  a_drop_o,
  output logic [DATA_WIDTH-1:0] a_rdata_o,
  output logic                  a_rvalid_o,
  output logic                  a_timeout_o,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [DATA_WIDTH-1:0] b_wdata_i,
  input  logic                  b_rw_i,
  input  logic                  b_valid_i,
  output logic                  b_busy_o,
  output logic                  b_drop_o,
  output logic [DATA_WIDTH-1:0] b_rdata_o,
  output logic                  b_rvalid_o,
  output logic                  b_timeout_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  output logic                  bus_rw_o,
  output logic                  bus_valid_o,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i,
  input  logic                  bus_rvalid_i
);

  localparam int TimerWidth = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e                 state_q, state_d;
  logic                   grant_q, grant_d;
  logic                   lastGrant_q, lastGrant_d;
  logic [TimerWidth-1:0]  timer_q, timer_d, timerInc;

  logic                   aBusy_q, aBusy_d, aRw_q, aRw_d, aDrop_q, aDrop_d;
  logic [ADDR_WIDTH-1:0]  aAddr_q, aAddr_d;
  logic [DATA_WIDTH-1:0]  aWdata_q, aWdata_d;
  logic                   bBusy_q, bBusy_d, bRw_q, bRw_d, bDrop_q, bDrop_d;
  logic [ADDR_WIDTH-1:0]  bAddr_q, bAddr_d;
  logic [DATA_WIDTH-1:0]  bWdata_q, bWdata_d;

  logic [DATA_WIDTH-1:0]  aRdata_q, aRdata_d, bRdata_q, bRdata_d;
  logic                   aRvalid_q, aRvalid_d, bRvalid_q, bRvalid_d;
  logic                   aTimeout_q, aTimeout_d, bTimeout_q, bTimeout_d;

  logic [ADDR_WIDTH-1:0]  busAddr_q, busAddr_d;
  logic [DATA_WIDTH-1:0]  busWdata_q, busWdata_d;
  logic                   busRw_q, busRw_d, busValid_q, busValid_d;

  logic                   aClear, bClear, pickB, respond, respondTimeout;
  logic [DATA_WIDTH-1:0]  rspData;

  // Tie goes to the requester that was not served last (grant 0 = A, 1 = B).
  assign pickB = bBusy_q && (!aBusy_q || !lastGrant_q);

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    lastGrant_d    = lastGrant_q;
    timer_d        = timer_q;
    timerInc       = (timer_q == '1) ? timer_q : timer_q + TimerWidth'(1);
    busAddr_d      = busAddr_q;
    busWdata_d     = busWdata_q;
    busRw_d        = busRw_q;
    busValid_d     = 1'b0;
    aRdata_d       = aRdata_q;
    bRdata_d       = bRdata_q;
    aRvalid_d      = 1'b0;
    bRvalid_d      = 1'b0;
    aTimeout_d     = 1'b0;
    bTimeout_d     = 1'b0;
    aClear         = 1'b0;
    bClear         = 1'b0;
    respond        = 1'b0;
    respondTimeout = 1'b0;
    rspData        = '0;

    case (state_q)
      IDLE: begin
        if (aBusy_q || bBusy_q) begin
          grant_d    = pickB;
          busAddr_d  = pickB ? bAddr_q  : aAddr_q;
          busWdata_d = pickB ? bWdata_q : aWdata_q;
          busRw_d    = pickB ? bRw_q    : aRw_q;
          busValid_d = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A real response beats a timeout that expires in the same cycle.
        if (bus_rvalid_i) begin
          respond = 1'b1;
          rspData = bus_rdata_i;
        end else if ((TIMEOUT > 0) && (timerInc == TimerWidth'(TIMEOUT))) begin
          respond        = 1'b1;
          respondTimeout = 1'b1;
        end else begin
          timer_d = timerInc;
        end
      end
      default: state_d = IDLE;
    endcase

    // Timeouts also rotate the grant so a dead target cannot starve the other side.
    if (respond) begin
      if (grant_q) begin
        bRvalid_d  = 1'b1;
        bRdata_d   = rspData;
        bTimeout_d = respondTimeout;
        bClear     = 1'b1;
      end else begin
        aRvalid_d  = 1'b1;
        aRdata_d   = rspData;
        aTimeout_d = respondTimeout;
        aClear     = 1'b1;
      end
      lastGrant_d = grant_q;
      state_d     = IDLE;
    end
  end

  always_comb begin
    aBusy_d  = aBusy_q;
    aAddr_d  = aAddr_q;
    aWdata_d = aWdata_q;
    aRw_d    = aRw_q;
    aDrop_d  = 1'b0;
    bBusy_d  = bBusy_q;
    bAddr_d  = bAddr_q;
    bWdata_d = bWdata_q;
    bRw_d    = bRw_q;
    bDrop_d  = 1'b0;
    if (aClear) aBusy_d = 1'b0;
    if (bClear) bBusy_d = 1'b0;
    if (a_valid_i) begin
      if (aBusy_q) begin
        aDrop_d = 1'b1;
      end else begin
        aBusy_d  = 1'b1;
        aAddr_d  = a_addr_i;
        aWdata_d = a_wdata_i;
        aRw_d    = a_rw_i;
      end
    end
    if (b_valid_i) begin
      if (bBusy_q) begin
        bDrop_d = 1'b1;
      end else begin
        bBusy_d  = 1'b1;
        bAddr_d  = b_addr_i;
        bWdata_d = b_wdata_i;
        bRw_d    = b_rw_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      timer_q     <= '0;
      aBusy_q     <= 1'b0;
      aAddr_q     <= '0;
      aWdata_q    <= '0;
      aRw_q       <= 1'b0;
      aDrop_q     <= 1'b0;
      bBusy_q     <= 1'b0;
      bAddr_q     <= '0;
      bWdata_q    <= '0;
      bRw_q       <= 1'b0;
      bDrop_q     <= 1'b0;
      aRdata_q    <= '0;
      bRdata_q    <= '0;
      aRvalid_q   <= 1'b0;
      bRvalid_q   <= 1'b0;
      aTimeout_q  <= 1'b0;
      bTimeout_q  <= 1'b0;
      busAddr_q   <= '0;
      busWdata_q  <= '0;
      busRw_q     <= 1'b0;
      busValid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      timer_q     <= timer_d;
      aBusy_q     <= aBusy_d;
      aAddr_q     <= aAddr_d;
      aWdata_q    <= aWdata_d;
      aRw_q       <= aRw_d;
      aDrop_q     <= aDrop_d;
      bBusy_q     <= bBusy_d;
      bAddr_q     <= bAddr_d;
      bWdata_q    <= bWdata_d;
      bRw_q       <= bRw_d;
      bDrop_q     <= bDrop_d;
      aRdata_q    <= aRdata_d;
      bRdata_q    <= bRdata_d;
      aRvalid_q   <= aRvalid_d;
      bRvalid_q   <= bRvalid_d;
      aTimeout_q  <= aTimeout_d;
      bTimeout_q  <= bTimeout_d;
      busAddr_q   <= busAddr_d;
      busWdata_q  <= busWdata_d;
      busRw_q     <= busRw_d;
      busValid_q  <= busValid_d;
    end
  end

  assign a_busy_o    = aBusy_q;
  assign a_drop_o    = aDrop_q;
  assign a_rdata_o   = aRdata_q;
  assign a_rvalid_o  = aRvalid_q;
  assign a_timeout_o = aTimeout_q;
  assign b_busy_o    = bBusy_q;
  assign b_drop_o    = bDrop_q;
  assign b_rdata_o   = bRdata_q;
  assign b_rvalid_o  = bRvalid_q;
  assign b_timeout_o = bTimeout_q;
  assign bus_addr_o  = busAddr_q;
  assign bus_wdata_o = busWdata_q;
  assign bus_rw_o    = busRw_q;
  assign bus_valid_o = busValid_q;

endmodule
